// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: exec_result, memory request/response and FSM
// encodings, plus the alignment rule and the state-to-output decode.
package load_store_unit_pkg;

    typedef enum logic [1:0] {MOP_NONE, MOP_LOAD, MOP_STORE} mem_op_t;
    typedef enum logic [1:0] {MSZ_B, MSZ_H, MSZ_W} mem_size_t;

    typedef struct packed {
        logic [4:0]  rd_idx;
        logic [31:0] rd_val;
        mem_op_t     mem_op;
        mem_size_t   mem_size;
        logic        mem_unsigned;
        logic [31:0] mem_wdata;
        logic        exc_misaligned;
    } exec_result_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic [31:0] rdata;
    } mtrans_t;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} lsu_state_t;

    typedef struct packed {
        logic ex_ready;
        logic req;
        logic resp;
        logic wb;
        logic busy;
    } lsu_outs_t;

    function automatic logic misaligned(mem_size_t size, logic [1:0] ea);
        case (size)
            MSZ_H:   return ea[0];
            MSZ_W:   return ea != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Output flags are registered alongside the state they belong to.
    function automatic lsu_outs_t outs_of(lsu_state_t s);
        lsu_outs_t o;
        o.ex_ready = (s == S_IDLE);
        o.req      = (s == S_REQ);
        o.resp     = (s == S_WAIT) || (s == S_DRAIN);
        o.wb       = (s == S_DONE);
        o.busy     = (s != S_IDLE);
        return o;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Decoupled channels around the LSU; master is the LSU side, slave is queue/commit/arbiter.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic         ex_valid;
    logic         ex_ready;
    exec_result_t ex_bits;

    logic         wb_valid;
    logic         wb_ready;
    exec_result_t wb_bits;

    logic         mem_req_valid;
    logic         mem_req_ready;
    mreq_t        mem_req_bits;

    logic         mem_resp_valid;
    logic         mem_resp_ready;
    mtrans_t      mem_resp_bits;

    modport master (
        input  ex_valid, ex_bits,
        output ex_ready,
        output wb_valid, wb_bits,
        input  wb_ready,
        output mem_req_valid, mem_req_bits,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_bits,
        output mem_resp_ready
    );

    modport slave (
        output ex_valid, ex_bits,
        input  ex_ready,
        input  wb_valid, wb_bits,
        output wb_ready,
        input  mem_req_valid, mem_req_bits,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_bits,
        input  mem_resp_ready
    );

endinterface

// File: rtl/load_store_unit_lane.sv
// Byte-lane datapath: byte enables and replicated store data for a request, and
// shift plus sign/zero extension of load data.
module lsu_lane
    import load_store_unit_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [1:0]  ea,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_val
);
    logic [31:0] sh;

    assign sh = rdata >> {ea, 3'b000};

    always_comb begin
        be     = 4'b1111;
        wdata  = wdata_in;
        ld_val = sh;
        case (size)
            MSZ_B: begin
                be     = 4'b0001 << ea;
                wdata  = {4{wdata_in[7:0]}};
                ld_val = {{24{sh[7] & ~is_unsigned}}, sh[7:0]};
            end
            MSZ_H: begin
                be     = 4'b0011 << {ea[1], 1'b0};
                wdata  = {2{wdata_in[15:0]}};
                ld_val = {{16{sh[15] & ~is_unsigned}}, sh[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one memory op in flight over arbiter port 1; every result, memory or not,
// leaves through a single-entry output slot towards commit.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit STORE_RESP = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.master bus,
    input  logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles
);
    lsu_state_t   state;
    lsu_outs_t    outs;
    exec_result_t ent;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic [31:0]  ld_val;
    logic         ex_fire;
    logic         req_fire;
    logic         resp_fire;
    logic         wb_fire;

    lsu_lane u_lane (
        .size        (ent.mem_size),
        .is_unsigned (ent.mem_unsigned),
        .ea          (ent.rd_val[1:0]),
        .wdata_in    (ent.mem_wdata),
        .rdata       (bus.mem_resp_bits.rdata),
        .be          (be),
        .wdata       (wdata),
        .ld_val      (ld_val)
    );

    // Flush masks intake and withdraws a pending request within the same cycle.
    assign bus.ex_ready       = outs.ex_ready & ~flush;
    assign bus.mem_req_valid  = outs.req & ~flush;
    assign bus.mem_req_bits   = '{addr:  {ent.rd_val[31:2], 2'b00},
                                  we:    (ent.mem_op == MOP_STORE),
                                  be:    be,
                                  wdata: wdata};
    assign bus.mem_resp_ready = outs.resp;
    assign bus.wb_valid       = outs.wb;
    assign bus.wb_bits        = ent;
    assign busy               = outs.busy;

    assign ex_fire   = bus.ex_valid & bus.ex_ready;
    assign req_fire  = bus.mem_req_valid & bus.mem_req_ready;
    assign resp_fire = bus.mem_resp_valid & bus.mem_resp_ready;
    assign wb_fire   = bus.wb_valid & bus.wb_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            outs  <= outs_of(S_IDLE);
            ent   <= '0;
        end else begin
            case (state)
                S_IDLE: if (ex_fire) begin
                    ent <= bus.ex_bits;
                    if (bus.ex_bits.mem_op == MOP_NONE) begin
                        state <= S_DONE;
                        outs  <= outs_of(S_DONE);
                    end else if (misaligned(bus.ex_bits.mem_size, bus.ex_bits.rd_val[1:0])) begin
                        ent.exc_misaligned <= 1'b1;
                        ent.rd_idx         <= '0;
                        state              <= S_DONE;
                        outs               <= outs_of(S_DONE);
                    end else begin
                        state <= S_REQ;
                        outs  <= outs_of(S_REQ);
                    end
                end
                S_REQ: if (flush) begin
                    state <= S_IDLE;
                    outs  <= outs_of(S_IDLE);
                end else if (req_fire) begin
                    if (ent.mem_op == MOP_STORE && !STORE_RESP) begin
                        state <= S_DONE;
                        outs  <= outs_of(S_DONE);
                    end else begin
                        state <= S_WAIT;
                        outs  <= outs_of(S_WAIT);
                    end
                end
                // A response landing in the flush cycle is already consumed: no drain needed.
                S_WAIT: if (resp_fire) begin
                    if (flush) begin
                        state <= S_IDLE;
                        outs  <= outs_of(S_IDLE);
                    end else begin
                        if (ent.mem_op == MOP_LOAD) ent.rd_val <= ld_val;
                        else                        ent.rd_idx <= '0;
                        state <= S_DONE;
                        outs  <= outs_of(S_DONE);
                    end
                end else if (flush) begin
                    state <= S_DRAIN;
                    outs  <= outs_of(S_DRAIN);
                end
                S_DONE: if (flush || wb_fire) begin
                    state <= S_IDLE;
                    outs  <= outs_of(S_IDLE);
                end
                S_DRAIN: if (resp_fire) begin
                    state <= S_IDLE;
                    outs  <= outs_of(S_IDLE);
                end
                default: begin
                    state <= S_IDLE;
                    outs  <= outs_of(S_IDLE);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (bus.mem_req_valid && !bus.mem_req_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a scoreboarded memory/commit model,
// then hand sequences for output back-pressure, flush and request stalls.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        busy, busy2;
    logic [31:0] stall;
    logic [1:0]  stall2;

    always #5 clk = ~clk;

    load_store_unit_if u ();
    load_store_unit_if v ();

    assign v.ex_valid       = u.ex_valid;
    assign v.ex_bits        = u.ex_bits;
    assign v.wb_ready       = u.wb_ready;
    assign v.mem_req_ready  = u.mem_req_ready;
    assign v.mem_resp_valid = u.mem_resp_valid;
    assign v.mem_resp_bits  = u.mem_resp_bits;

    load_store_unit #(.STORE_RESP(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(u.master), .flush(flush), .busy(busy), .stall_cycles(stall));

    load_store_unit #(.STORE_RESP(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(v.master), .flush(flush), .busy(busy2), .stall_cycles(stall2));

    typedef struct {
        mem_op_t     op;
        mem_size_t   sz;
        logic        usg;
        logic [4:0]  rd;
        logic [31:0] ea;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic        e_exc;
        int          lat;
    } vec_t;

    int           vectors = 0;
    int           fails = 0;
    int           cyc = 0;
    exec_result_t exp_wb[$];
    mreq_t        exp_req[$];
    bit           ex_pend = 1'b0;
    exec_result_t ex_cur = '0;
    bit           flush_next = 1'b0;
    int           req_hold = 0;
    int           wb_hold = 0;
    int           resp_lat = 0;
    int           resp_delay = 0;
    bit           resp_pending = 1'b0;
    bit           req_fired = 1'b0;
    logic [31:0]  resp_rdata = '0;
    logic [31:0]  next_rdata = '0;
    int           t_ex = 0;
    int           cur_lat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // One clock: drive at negedge, settle, then score whatever will fire at the next posedge.
    task automatic cycle();
        mreq_t        r;
        exec_result_t e;
        @(negedge clk);
        cyc++;
        flush            = flush_next;
        u.ex_valid       = ex_pend;
        u.ex_bits        = ex_cur;
        u.mem_req_ready  = (req_hold == 0);
        u.wb_ready       = (wb_hold == 0);
        u.mem_resp_valid = resp_pending && (resp_delay == 0);
        u.mem_resp_bits.rdata = resp_rdata;
        #1;
        if (u.ex_valid && u.ex_ready) begin
            ex_pend = 1'b0;
            t_ex    = cyc;
        end
        if (u.mem_resp_valid && u.mem_resp_ready) resp_pending = 1'b0;
        else if (resp_pending && resp_delay > 0) resp_delay--;
        if (u.mem_req_valid) begin
            if (exp_req.size() == 0) flag("unexpected mem_req.valid");
            else if (u.mem_req_ready) begin
                r = exp_req.pop_front();
                chk("req.addr",  u.mem_req_bits.addr, r.addr);
                chk("req.we",    32'(u.mem_req_bits.we), 32'(r.we));
                chk("req.be",    32'(u.mem_req_bits.be), 32'(r.be));
                chk("req.wdata", u.mem_req_bits.wdata, r.wdata);
                req_fired    = 1'b1;
                resp_pending = 1'b1;
                resp_delay   = resp_lat;
                resp_rdata   = next_rdata;
            end else if (req_hold > 0) req_hold--;
        end
        if (u.wb_valid && u.wb_ready) begin
            if (exp_wb.size() == 0) flag("unexpected wb_out fire");
            else begin
                e = exp_wb.pop_front();
                chk("wb.rd_idx", 32'(u.wb_bits.rd_idx), 32'(e.rd_idx));
                chk("wb.rd_val", u.wb_bits.rd_val, e.rd_val);
                chk("wb.exc_misaligned", 32'(u.wb_bits.exc_misaligned), 32'(e.exc_misaligned));
                if (cur_lat > 0) chk("wb.latency", 32'(cyc - t_ex), 32'(cur_lat));
            end
        end else if (u.wb_valid && wb_hold > 0) wb_hold--;
    endtask

    task automatic run_idle(input string name);
        int n;
        n = 0;
        while ((ex_pend || exp_wb.size() != 0 || resp_pending) && n < 60) begin
            cycle();
            n++;
        end
        if (ex_pend || exp_wb.size() != 0 || resp_pending) begin
            flag({name, " timeout"});
            ex_pend = 1'b0;
            resp_pending = 1'b0;
            exp_wb.delete();
            exp_req.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt[12];
        exec_result_t x, e;
        mreq_t        r;
        int           n;

        vt[0]  = '{MOP_LOAD,  MSZ_B, 1'b0, 5'd3,  32'h80000003, 32'h0, 32'h80FFFFFF,
                   1'b1, 32'h80000000, 1'b0, 4'b1000, 32'h0, 5'd3, 32'hFFFFFF80, 1'b0, 0};
        vt[1]  = '{MOP_LOAD,  MSZ_B, 1'b1, 5'd4,  32'h80000003, 32'h0, 32'h80FFFFFF,
                   1'b1, 32'h80000000, 1'b0, 4'b1000, 32'h0, 5'd4, 32'h00000080, 1'b0, 0};
        vt[2]  = '{MOP_STORE, MSZ_H, 1'b0, 5'd9,  32'h10000002, 32'h1234ABCD, 32'h0,
                   1'b1, 32'h10000000, 1'b1, 4'b1100, 32'hABCDABCD, 5'd0, 32'h10000002, 1'b0, 0};
        vt[3]  = '{MOP_LOAD,  MSZ_W, 1'b0, 5'd6,  32'h10000001, 32'h0, 32'h0,
                   1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 5'd0, 32'h10000001, 1'b1, 1};
        vt[4]  = '{MOP_NONE,  MSZ_B, 1'b0, 5'd5,  32'h00000007, 32'h0, 32'h0,
                   1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 5'd5, 32'h00000007, 1'b0, 1};
        vt[5]  = '{MOP_LOAD,  MSZ_H, 1'b0, 5'd7,  32'h20000002, 32'h0, 32'h80011234,
                   1'b1, 32'h20000000, 1'b0, 4'b1100, 32'h0, 5'd7, 32'hFFFF8001, 1'b0, 0};
        vt[6]  = '{MOP_LOAD,  MSZ_H, 1'b1, 5'd8,  32'h20000000, 32'h0, 32'h8001F234,
                   1'b1, 32'h20000000, 1'b0, 4'b0011, 32'h0, 5'd8, 32'h0000F234, 1'b0, 0};
        vt[7]  = '{MOP_LOAD,  MSZ_W, 1'b0, 5'd10, 32'h30000004, 32'h0, 32'hDEADBEEF,
                   1'b1, 32'h30000004, 1'b0, 4'b1111, 32'h0, 5'd10, 32'hDEADBEEF, 1'b0, 0};
        vt[8]  = '{MOP_STORE, MSZ_B, 1'b0, 5'd11, 32'h40000001, 32'h000000A5, 32'h0,
                   1'b1, 32'h40000000, 1'b1, 4'b0010, 32'hA5A5A5A5, 5'd0, 32'h40000001, 1'b0, 0};
        vt[9]  = '{MOP_STORE, MSZ_W, 1'b0, 5'd12, 32'h40000008, 32'h11223344, 32'h0,
                   1'b1, 32'h40000008, 1'b1, 4'b1111, 32'h11223344, 5'd0, 32'h40000008, 1'b0, 0};
        vt[10] = '{MOP_STORE, MSZ_H, 1'b0, 5'd13, 32'h50000003, 32'h00005555, 32'h0,
                   1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 5'd0, 32'h50000003, 1'b1, 1};
        vt[11] = '{MOP_LOAD,  MSZ_B, 1'b0, 5'd14, 32'h60000001, 32'h0, 32'h00007F00,
                   1'b1, 32'h60000000, 1'b0, 4'b0010, 32'h0, 5'd14, 32'h0000007F, 1'b0, 0};

        u.ex_valid = 1'b0; u.ex_bits = '0; u.wb_ready = 1'b0;
        u.mem_req_ready = 1'b0; u.mem_resp_valid = 1'b0; u.mem_resp_bits = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        cycle();
        chk("reset.wb_valid",       32'(u.wb_valid), 32'd0);
        chk("reset.mem_req_valid",  32'(u.mem_req_valid), 32'd0);
        chk("reset.mem_resp_ready", 32'(u.mem_resp_ready), 32'd0);
        chk("reset.busy",           32'(busy), 32'd0);
        chk("reset.stall_cycles",   stall, 32'd0);
        chk("reset.ex_ready",       32'(u.ex_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            x = '0;
            x.rd_idx = vt[i].rd; x.rd_val = vt[i].ea; x.mem_op = vt[i].op;
            x.mem_size = vt[i].sz; x.mem_unsigned = vt[i].usg; x.mem_wdata = vt[i].wd;
            e = x;
            e.rd_idx = vt[i].e_rd; e.rd_val = vt[i].e_val; e.exc_misaligned = vt[i].e_exc;
            exp_wb.push_back(e);
            if (vt[i].e_req) begin
                r = '{addr: vt[i].e_addr, we: vt[i].e_we, be: vt[i].e_be, wdata: vt[i].e_wdata};
                exp_req.push_back(r);
            end
            next_rdata = vt[i].rdata;
            cur_lat    = vt[i].lat;
            ex_cur     = x;
            ex_pend    = 1'b1;
            run_idle("vector");
        end
        cur_lat = 0;

        // Output slot held by commit back-pressure.
        x = '0; x.rd_idx = 5'd5; x.rd_val = 32'd7;
        exp_wb.push_back(x);
        wb_hold = 3; ex_cur = x; ex_pend = 1'b1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("hold.wb_valid", 32'(u.wb_valid), 32'd1);
            chk("hold.rd_idx",   32'(u.wb_bits.rd_idx), 32'd5);
            chk("hold.rd_val",   u.wb_bits.rd_val, 32'd7);
            chk("hold.ex_ready", 32'(u.ex_ready), 32'd0);
        end
        run_idle("hold");

        // Flush while waiting for a load response.
        x = '0; x.rd_idx = 5'd2; x.rd_val = 32'h70000000; x.mem_op = MOP_LOAD; x.mem_size = MSZ_W;
        exp_req.push_back('{addr: 32'h70000000, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        next_rdata = 32'h12345678; resp_lat = 4; req_fired = 1'b0;
        ex_cur = x; ex_pend = 1'b1;
        n = 0;
        while (!req_fired && n < 20) begin cycle(); n++; end
        if (!req_fired) flag("flush.req timeout");
        flush_next = 1'b1;
        cycle();
        chk("flush.resp_ready", 32'(u.mem_resp_ready), 32'd1);
        chk("flush.busy",       32'(busy), 32'd1);
        flush_next = 1'b0;
        n = 0;
        while (resp_pending && n < 20) begin cycle(); n++; end
        if (resp_pending) flag("flush.drain timeout");
        cycle();
        chk("flush.ex_ready_after", 32'(u.ex_ready), 32'd1);
        chk("flush.busy_after",     32'(busy), 32'd0);
        resp_lat = 0;

        // Request back-pressure drives the stall counter; the 2-bit copy saturates.
        chk("stall.before", stall, 32'd0);
        x = '0; x.rd_idx = 5'd1; x.rd_val = 32'h00000010; x.mem_op = MOP_LOAD; x.mem_size = MSZ_W;
        exp_req.push_back('{addr: 32'h00000010, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        e = x; e.rd_val = 32'hCAFEF00D;
        exp_wb.push_back(e);
        next_rdata = 32'hCAFEF00D; req_hold = 10;
        ex_cur = x; ex_pend = 1'b1;
        run_idle("stall");
        chk("stall.cnt32", stall, 32'd10);
        chk("stall.cnt2",  32'(stall2), 32'd3);

        // Flush withdraws a request the arbiter has not accepted.
        x = '0; x.rd_val = 32'h00000020; x.mem_op = MOP_STORE; x.mem_size = MSZ_W; x.mem_wdata = 32'h55AA55AA;
        exp_req.push_back('{addr: 32'h00000020, we: 1'b1, be: 4'b1111, wdata: 32'h55AA55AA});
        req_hold = 100; ex_cur = x; ex_pend = 1'b1;
        cycle();
        cycle();
        chk("wdraw.valid_before", 32'(u.mem_req_valid), 32'd1);
        flush_next = 1'b1;
        cycle();
        chk("wdraw.valid_flush", 32'(u.mem_req_valid), 32'd0);
        flush_next = 1'b0;
        exp_req.delete();
        req_hold = 0;
        cycle();
        chk("wdraw.valid_after", 32'(u.mem_req_valid), 32'd0);
        chk("wdraw.busy",        32'(busy), 32'd0);
        chk("wdraw.ex_ready",    32'(u.ex_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
